// File: rtl/pc_control_pkg.sv
// pc_control_pkg -- shared definitions for the multicycle PC / sequencing
// controller: FSM state encoding, opcode/funct constants, and the mux-select
// codes driven onto the datapath (pc_source, alu_op, alu_src_b, reg_dst,
// mem_to_reg). Also holds the DECODE dispatch function.
package pc_control_pkg;

  typedef enum logic [3:0] {
    FETCH,
    DECODE,
    R_EXEC,
    R_WB,
    ADDI_EXEC,
    ADDI_WB,
    BRANCH,
    JUMP,
    JAL,
    JR,
    HALT
  } state_t;

  // Opcode field (instr[31:26]) and funct field (instr[5:0]) values.
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] FN_JR    = 6'h08;

  // PC-source mux select.
  localparam logic [1:0] PCSRC_ALUOUT = 2'b00;  // branch target held in ALUOut
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;  // jump target
  localparam logic [1:0] PCSRC_ALU    = 2'b11;  // live ALU result

  // ALU operation codes.
  localparam logic [2:0] ALU_ADD    = 3'b000;
  localparam logic [2:0] ALU_SUB    = 3'b001;
  localparam logic [2:0] ALU_FUNCT  = 3'b010;
  localparam logic [2:0] ALU_PASS_A = 3'b011;

  // ALU B-operand select.
  localparam logic [1:0] SRCB_REGB    = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

  // Register-file destination and write-back source.
  localparam logic [1:0] DST_RT    = 2'b00;
  localparam logic [1:0] DST_RD    = 2'b01;
  localparam logic [1:0] DST_RA    = 2'b10;
  localparam logic [1:0] WB_ALUOUT = 2'b00;
  localparam logic [1:0] WB_PC     = 2'b10;

  // State entered after DECODE for a given instruction.
  function automatic state_t dispatch(input logic [5:0] opcode,
                                      input logic [5:0] funct);
    state_t s;
    case (opcode)
      OP_RTYPE:       s = (funct == FN_JR) ? JR : R_EXEC;
      OP_ADDI:        s = ADDI_EXEC;
      OP_BEQ, OP_BNE: s = BRANCH;
      OP_J:           s = JUMP;
      OP_JAL:         s = JAL;
      default:        s = HALT;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/pc_control_wait_counter.sv
// wait_counter -- 3-bit instruction-fetch wait counter.
// Ports:
//   clk, reset  clock and asynchronous active-low reset
//   clear       synchronous clear to 0 (takes priority over en)
//   en          count up by one
//   tc          terminal count: count == LIMIT-1
// The owner clears the counter on the terminal cycle, so it never counts
// past LIMIT-1.
module wait_counter #(
  parameter int LIMIT = 3
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic en,
  output logic tc
);

  localparam logic [2:0] LAST = 3'(LIMIT - 1);

  logic [2:0] count;

  // NOTE: sequential state uses non-blocking (<=) so every flop samples
  // pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)     count <= '0;
    else if (clear) count <= '0;
    else if (en)    count <= count + 3'd1;
  end

  assign tc = (count == LAST);

endmodule

// File: rtl/pc_control.sv
// pc_control -- multicycle MIPS-style sequencing controller.
// Ports:
//   clk, reset   clock, asynchronous active-low reset
//   opcode/funct instruction fields, valid from DECODE onward
//   zero         ALU zero flag (used by BRANCH only)
//   pc_write, pc_source            PC load enable and source select
//   mem_read, ir_write             instruction fetch strobes
//   alu_src_a, alu_src_b, alu_op   ALU operand / operation selects
//   reg_write, reg_dst, mem_to_reg register-file write controls
//   exception    unsupported instruction, held in HALT until reset
// Outputs decode from state only (plus zero/opcode for the branch decision)
// and are forced to 0 combinationally while reset is low.
module pc_control
  import pc_control_pkg::*;
#(
  parameter int MEM_LAT = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       zero,
  output logic       pc_write,
  output logic [1:0] pc_source,
  output logic       mem_read,
  output logic       ir_write,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [2:0] alu_op,
  output logic       reg_write,
  output logic [1:0] reg_dst,
  output logic [1:0] mem_to_reg,
  output logic       exception
);

  state_t state, next_state;
  logic   in_fetch, fetch_done;

  assign in_fetch = (state == FETCH);

  // Cleared outside FETCH and on the last fetch cycle, so every fetch
  // starts counting from 0.
  wait_counter #(.LIMIT(MEM_LAT)) u_wait (
    .clk   (clk),
    .reset (reset),
    .clear (!in_fetch || fetch_done),
    .en    (in_fetch),
    .tc    (fetch_done)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= FETCH;
    else        state <= next_state;
  end

  always_comb begin
    // NOTE: every output gets a default before the case; a path that leaves
    // one unassigned would infer a latch.
    next_state = state;
    pc_write   = 1'b0;
    pc_source  = PCSRC_ALUOUT;
    mem_read   = 1'b0;
    ir_write   = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = SRCB_REGB;
    alu_op     = ALU_ADD;
    reg_write  = 1'b0;
    reg_dst    = DST_RT;
    mem_to_reg = WB_ALUOUT;
    exception  = 1'b0;

    case (state)
      FETCH: begin
        mem_read = 1'b1;
        if (fetch_done) begin
          // Latch the instruction and advance PC <= PC + 4 together.
          ir_write   = 1'b1;
          pc_write   = 1'b1;
          pc_source  = PCSRC_ALU;
          alu_src_b  = SRCB_FOUR;
          next_state = DECODE;
        end
      end
      DECODE: begin
        // Speculatively compute PC + (imm << 2) into ALUOut for BRANCH.
        alu_src_b  = SRCB_IMM_SH2;
        next_state = dispatch(opcode, funct);
      end
      R_EXEC: begin
        alu_src_a  = 1'b1;
        alu_op     = ALU_FUNCT;
        next_state = R_WB;
      end
      R_WB: begin
        reg_write  = 1'b1;
        reg_dst    = DST_RD;
        next_state = FETCH;
      end
      ADDI_EXEC: begin
        alu_src_a  = 1'b1;
        alu_src_b  = SRCB_IMM;
        next_state = ADDI_WB;
      end
      ADDI_WB: begin
        reg_write  = 1'b1;
        next_state = FETCH;
      end
      BRANCH: begin
        alu_src_a  = 1'b1;
        alu_op     = ALU_SUB;
        pc_write   = (opcode == OP_BNE) ? !zero : zero;
        next_state = FETCH;
      end
      JUMP: begin
        pc_write   = 1'b1;
        pc_source  = PCSRC_JUMP;
        next_state = FETCH;
      end
      JAL: begin
        // Link (PC -> $31) and jump in the same cycle.
        reg_write  = 1'b1;
        reg_dst    = DST_RA;
        mem_to_reg = WB_PC;
        pc_write   = 1'b1;
        pc_source  = PCSRC_JUMP;
        next_state = FETCH;
      end
      JR: begin
        alu_src_a  = 1'b1;
        alu_op     = ALU_PASS_A;
        pc_write   = 1'b1;
        pc_source  = PCSRC_ALU;
        next_state = FETCH;
      end
      HALT: begin
        exception = 1'b1;
      end
      default: next_state = FETCH;
    endcase

    // Reset kills all outputs immediately, without waiting for a clock edge,
    // so an aborted instruction cannot emit a further write pulse.
    if (!reset) begin
      pc_write   = 1'b0;
      pc_source  = PCSRC_ALUOUT;
      mem_read   = 1'b0;
      ir_write   = 1'b0;
      alu_src_a  = 1'b0;
      alu_src_b  = SRCB_REGB;
      alu_op     = ALU_ADD;
      reg_write  = 1'b0;
      reg_dst    = DST_RT;
      mem_to_reg = WB_ALUOUT;
      exception  = 1'b0;
    end
  end

endmodule

// File: doc/pc_control.md
PC_CONTROL -- requirements
Module: pc_control

Interface
REQ-001 Parameter MEM_LAT, default 3: instruction-memory read latency in cycles, legal range 1..7.
REQ-002 clk  in  1  single system clock, all state updates on rising edge.
REQ-003 reset  in  1  asynchronous, active-low reset.
REQ-004 opcode  in  6  instruction bits [31:26], valid from DECODE onward.
REQ-005 funct  in  6  instruction bits [5:0], valid from DECODE onward.
REQ-006 zero  in  1  ALU zero flag, same cycle as the ALU operation.
REQ-007 pc_write  out  1  PC register load enable.
REQ-008 pc_source  out  2  PC-source mux select: 2'b11 ALU result, 2'b00 ALUOut (branch target), 2'b10 jump target.
REQ-009 mem_read  out  1  instruction-memory read strobe.
REQ-010 ir_write  out  1  instruction-register load enable.
REQ-011 alu_src_a  out  1  0 = PC, 1 = register A.
REQ-012 alu_src_b  out  2  00 = register B, 01 = constant 4, 10 = sign-extended imm, 11 = sign-extended imm << 2.
REQ-013 alu_op  out  3  000 ADD, 001 SUB, 010 decode funct, 011 PASS_A.
REQ-014 reg_write, reg_dst[1:0] (00 rt, 01 rd, 10 $31), mem_to_reg[1:0] (00 ALUOut, 10 PC)  out  register-file write controls.
REQ-015 exception  out  1  unsupported instruction flag.

Function
REQ-016 States: FETCH, DECODE, R_EXEC, R_WB, ADDI_EXEC, ADDI_WB, BRANCH, JUMP, JAL, JR, HALT.
REQ-017 Outputs are decoded from state only, except pc_write in BRANCH, which also depends on zero.
REQ-018 Every output not set by the current state is 0.
REQ-019 FETCH: mem_read=1 for MEM_LAT cycles, counted by a 3-bit wait counter.
REQ-020 FETCH last cycle: ir_write=1, pc_write=1, pc_source=11, alu_src_a=0, alu_src_b=01, alu_op=ADD; next state is DECODE.
REQ-021 DECODE: alu_src_a=0, alu_src_b=11, alu_op=ADD (precomputes the branch target into ALUOut).
REQ-022 DECODE dispatch: opcode 0x00 with funct 0x08 -> JR; other opcode 0x00 -> R_EXEC; 0x08 -> ADDI_EXEC; 0x04/0x05 -> BRANCH; 0x02 -> JUMP; 0x03 -> JAL; any other opcode -> HALT.
REQ-023 R_EXEC: alu_src_a=1, alu_src_b=00, alu_op=010, then R_WB.
REQ-024 R_WB: reg_write=1, reg_dst=01, mem_to_reg=00, then FETCH.
REQ-025 ADDI_EXEC: alu_src_a=1, alu_src_b=10, alu_op=ADD, then ADDI_WB.
REQ-026 ADDI_WB: reg_write=1, reg_dst=00, then FETCH.
REQ-027 BRANCH: alu_src_a=1, alu_src_b=00, alu_op=SUB, pc_source=00.
REQ-028 BRANCH: pc_write = zero for opcode 0x04 and pc_write = !zero for opcode 0x05; next state is FETCH.
REQ-029 JUMP: pc_write=1, pc_source=10, then FETCH.
REQ-030 JAL: reg_write=1, reg_dst=10, mem_to_reg=10, pc_write=1, pc_source=10 in the same cycle, then FETCH.
REQ-031 JR: alu_src_a=1, alu_op=PASS_A, pc_write=1, pc_source=11, then FETCH.
REQ-032 HALT: exception=1, all write enables 0; HALT is held until reset.
REQ-033 Instruction latency: R-type and ADDI take MEM_LAT+3 cycles; branch, J, JAL and JR take MEM_LAT+2 cycles.
REQ-034 The wait counter clears on entry to FETCH and never wraps past MEM_LAT-1.
REQ-035 pc_write is asserted for at most one cycle per instruction outside FETCH.

Reset
REQ-036 While reset=0: state=FETCH, wait counter=0, all outputs 0 (pc_source=00, exception=0).
REQ-037 Reset asserted mid-instruction aborts the instruction immediately, with no further write-enable pulses.
REQ-038 After reset deassertion, fetch begins on the first rising edge.

Structure
REQ-039 State encodings, opcode/funct constants, pc_source codes and alu_op codes reside in a shared definitions package/header used by the datapath.
REQ-040 The fetch wait counter is one sub-module, wait_counter (load/clear, terminal-count output).
REQ-041 All other logic is flat within pc_control.

Verification
REQ-042 MEM_LAT=3, opcode 0x00, funct 0x20 -> ir_write pulses on cycle 3; R_WB has reg_write=1, reg_dst=01; next fetch mem_read starts on cycle 7.
REQ-043 beq with zero=1 -> BRANCH pc_write=1, pc_source=00; same test with zero=0 -> pc_write stays 0.
REQ-044 bne with zero=0 -> pc_write=1; bne with zero=1 -> pc_write=0.
REQ-045 jal -> one cycle with reg_write=1, reg_dst=10, mem_to_reg=10, pc_write=1, pc_source=10.
REQ-046 opcode 0x3F -> exception=1 held for 20 cycles with no write enables; reset=0 then 1 -> normal fetch resumes.
REQ-047 reset=0 asserted during R_EXEC -> all outputs 0 asynchronously, before the next edge; no reg_write pulse occurs.
